dbus_sramx_bridge: RTL and testbench

Sequential bridge between the core's data-bus request/response handshake and a synchronous SRAM-like data port with fixed one-cycle read latency. It sits between the core's data-side interface and the data SRAM pins, in place of a purely combinational converter. It issues at most one SRAM access per cycle and sustains back-to-back throughput. A response buffer lets the core apply backpressure without losing SRAM read data.

---
 rtl/dbus_sramx_bridge_if.sv | 26 ++
 rtl/dbus_sramx_bridge.sv | 106 ++++++++++
 tb/tb_dbus_sramx_bridge.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/dbus_sramx_bridge_if.sv
// Core data-bus request/response handshake between the core (master) and the SRAM bridge (slave).
interface dbus_sramx_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    req_valid;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [1:0]              req_size;
  logic [DATA_WIDTH/8-1:0] req_strobe;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    addr_ok;
  logic                    data_ok;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic                    resp_err;
  logic                    resp_ready;

  modport master (
    output req_valid, req_addr, req_size, req_strobe, req_wdata, resp_ready,
    input  addr_ok, data_ok, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_size, req_strobe, req_wdata, resp_ready,
    output addr_ok, data_ok, resp_rdata, resp_err
  );
endinterface

// File: rtl/dbus_sramx_bridge.sv
// Data-bus to 1-cycle-latency SRAM bridge; DBUS_SRAMX_ALIGN_CHECK_EN enables misaligned-access errors.
// Latency: response one cycle after accept, later only while the core backpressures.
// Backpressure: an unconsumed response is parked in a buffer and no new request is accepted.
module dbus_sramx_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  dbus_sramx_bridge_if.slave      bus,
  output logic                    sram_en,
  output logic [DATA_WIDTH/8-1:0] sram_wen,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic [DATA_WIDTH-1:0]   sram_wdata,
  input  logic [DATA_WIDTH-1:0]   sram_rdata
);
  typedef enum logic [1:0] {IDLE, PEND, HOLD} state_t;

  state_t                state, state_nxt;
  logic                  pend_wr;
  logic                  pend_err;
  logic                  buf_err;
  logic [DATA_WIDTH-1:0] buf_rdata;
  logic [DATA_WIDTH-1:0] pend_rdata;
  logic                  accept;
  logic                  misaligned;
  logic                  issue;
  logic                  capture;

`ifdef DBUS_SRAMX_ALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    case (bus.req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = bus.req_addr[0];
      default: misaligned = |bus.req_addr[1:0];
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // A new request may only enter when the presented response (if any) leaves this cycle.
  assign accept = bus.req_valid && !reset && (state == IDLE || bus.resp_ready);
  assign issue  = accept && !misaligned;

  assign bus.addr_ok = accept;
  assign sram_en     = issue;
  assign sram_wen    = issue  ? bus.req_strobe : '0;
  assign sram_addr   = accept ? bus.req_addr   : '0;
  assign sram_wdata  = accept ? bus.req_wdata  : '0;

  // Writes and rejected accesses never forward whatever sits on the SRAM read bus.
  assign pend_rdata = (pend_wr || pend_err) ? '0 : sram_rdata;

  always_comb begin
    state_nxt      = state;
    capture        = 1'b0;
    bus.data_ok    = 1'b0;
    bus.resp_rdata = '0;
    bus.resp_err   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = PEND;
      end
      PEND: begin
        bus.data_ok    = 1'b1;
        bus.resp_rdata = pend_rdata;
        bus.resp_err   = pend_err;
        if (bus.resp_ready) begin
          state_nxt = accept ? PEND : IDLE;
        end else begin
          state_nxt = HOLD;
          capture   = 1'b1;
        end
      end
      HOLD: begin
        bus.data_ok    = 1'b1;
        bus.resp_rdata = buf_rdata;
        bus.resp_err   = buf_err;
        if (bus.resp_ready) state_nxt = accept ? PEND : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pend_wr   <= 1'b0;
      pend_err  <= 1'b0;
      buf_rdata <= '0;
      buf_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        pend_wr  <= |bus.req_strobe;
        pend_err <= misaligned;
      end
      if (capture) begin
        buf_rdata <= pend_rdata;
        buf_err   <= pend_err;
      end
    end
  end
endmodule

// File: tb/tb_dbus_sramx_bridge.sv
// Directed and random bench for dbus_sramx_bridge against a queue-based response model and a behavioural SRAM.
module tb_dbus_sramx_bridge;
`ifdef DBUS_SRAMX_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  logic [32:0] exp_q [$];
  logic        last_acc;

  dbus_sramx_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();

  dbus_sramx_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .sram_en    (sram_en),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 clk = ~clk;

  // Read data is only meaningful after a read; other cycles carry noise.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      sram_rdata <= '0;
    end else if (sram_en && sram_wen == 4'h0) begin
      sram_rdata <= mem[sram_addr[5:2]];
    end else begin
      sram_rdata <= $urandom;
      if (sram_en)
        for (int b = 0; b < 4; b++)
          if (sram_wen[b]) mem[sram_addr[5:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic bench_mis(input logic [31:0] a, input logic [1:0] sz);
    int unsigned bytes;
    bytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    return ALIGN_EN && ((a % bytes) != 0);
  endfunction

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
  endtask

  // One bus cycle: drive after the edge, compare mid-cycle, advance the model.
  task automatic step(input logic v, input logic [31:0] a, input logic [1:0] sz,
                      input logic [3:0] st, input logic [31:0] wd, input logic rr);
    logic        exp_dok, exp_aok, exp_mis, exp_iss;
    logic [32:0] rsp;
    logic [31:0] w;
    bus.req_valid  = v;
    bus.req_addr   = a;
    bus.req_size   = sz;
    bus.req_strobe = st;
    bus.req_wdata  = wd;
    bus.resp_ready = rr;
    @(negedge clk);
    exp_dok = exp_q.size() != 0;
    exp_aok = v && (!exp_dok || rr);
    exp_mis = bench_mis(a, sz);
    exp_iss = exp_aok && !exp_mis;
    chk("addr_ok", 32'(bus.addr_ok), 32'(exp_aok));
    chk("data_ok", 32'(bus.data_ok), 32'(exp_dok));
    if (exp_dok) begin
      chk("resp_rdata", bus.resp_rdata, exp_q[0][31:0]);
      chk("resp_err", 32'(bus.resp_err), 32'(exp_q[0][32]));
    end
    chk("sram_en", 32'(sram_en), 32'(exp_iss));
    chk("sram_wen", 32'(sram_wen), 32'(exp_iss ? st : 4'h0));
    chk("sram_addr", sram_addr, exp_aok ? a : 32'h0);
    chk("sram_wdata", sram_wdata, exp_aok ? wd : 32'h0);
    if (exp_dok && rr) void'(exp_q.pop_front());
    if (exp_aok) begin
      if (exp_mis) begin
        rsp = {1'b1, 32'h0};
      end else if (st == 4'h0) begin
        rsp = {1'b0, ref_mem[a[5:2]]};
      end else begin
        w = ref_mem[a[5:2]];
        for (int b = 0; b < 4; b++) if (st[b]) w[8*b +: 8] = wd[8*b +: 8];
        ref_mem[a[5:2]] = w;
        rsp = {1'b0, 32'h0};
      end
      exp_q.push_back(rsp);
    end
    last_acc = exp_aok;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        hv;
    logic [31:0] ha, hw;
    logic [1:0]  hs;
    logic [3:0]  hst;

    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h0000_0010;
    bus.req_size   = 2'd2;
    bus.req_strobe = 4'hF;
    bus.req_wdata  = 32'h5A5A_5A5A;
    bus.resp_ready = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr_ok", 32'(bus.addr_ok), 32'h0);
    chk("rst_data_ok", 32'(bus.data_ok), 32'h0);
    chk("rst_rdata", bus.resp_rdata, 32'h0);
    chk("rst_err", 32'(bus.resp_err), 32'h0);
    chk("rst_sram_en", 32'(sram_en), 32'h0);
    chk("rst_sram_wen", 32'(sram_wen), 32'h0);
    chk("rst_sram_addr", sram_addr, 32'h0);
    chk("rst_sram_wdata", sram_wdata, 32'h0);
    reset = 1'b0;

    // Single read of a preloaded word.
    step(1, 32'h10, 2, 4'hF, 32'hDEAD_BEEF, 1);
    step(1, 32'h10, 2, 4'h0, 32'h0, 1);
    step(0, 32'h0, 2, 4'h0, 32'h0, 1);
    chk("single_read_rdata", 32'(exp_q.size()), 32'h0);

    // Back-to-back writes then reads, one access per cycle.
    for (int i = 0; i < 4; i++) step(1, 32'(4*i), 2, 4'hF, 32'h1111_0000 + 32'(i), 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 32'(4*i), 2, 4'h0, 32'h0, 1);
      chk("b2b_accept", 32'(last_acc), 32'h1);
    end
    step(0, 32'h0, 2, 4'h0, 32'h0, 1);

    // Backpressure: response held three cycles, waiting request accepted on release.
    step(1, 32'h14, 2, 4'hF, 32'h1234_5678, 1);
    step(1, 32'h14, 2, 4'h0, 32'h0, 1);
    repeat (3) step(1, 32'h18, 2, 4'h0, 32'h0, 0);
    step(1, 32'h18, 2, 4'h0, 32'h0, 1);
    chk("bp_release_accept", 32'(last_acc), 32'h1);
    step(0, 32'h0, 2, 4'h0, 32'h0, 1);

    // Partial write returns zero read data.
    step(1, 32'h20, 2, 4'b0011, 32'hAABB_CCDD, 1);
    step(0, 32'h0, 2, 4'h0, 32'h0, 1);
    step(1, 32'h20, 2, 4'h0, 32'h0, 1);
    step(0, 32'h0, 2, 4'h0, 32'h0, 1);

    // Misaligned word read (error only when the alignment check is built in).
    step(1, 32'h2, 2, 4'h0, 32'h0, 1);
    step(1, 32'h5, 1, 4'h0, 32'h0, 1);
    step(1, 32'h7, 0, 4'h0, 32'h0, 1);
    step(0, 32'h0, 2, 4'h0, 32'h0, 1);

    // Reset while a read is pending.
    step(1, 32'h10, 2, 4'h0, 32'h0, 1);
    bus.req_strobe = 4'hF;
    bus.req_wdata  = 32'hCAFE_F00D;
    reset = 1'b1;
    #1;
    chk("midrst_data_ok", 32'(bus.data_ok), 32'h0);
    chk("midrst_addr_ok", 32'(bus.addr_ok), 32'h0);
    chk("midrst_sram_en", 32'(sram_en), 32'h0);
    chk("midrst_sram_wen", 32'(sram_wen), 32'h0);
    chk("midrst_sram_addr", sram_addr, 32'h0);
    chk("midrst_sram_wdata", sram_wdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_model();
    step(0, 32'h0, 2, 4'h0, 32'h0, 0);
    step(1, 32'h8, 2, 4'h0, 32'h0, 0);
    step(0, 32'h0, 2, 4'h0, 32'h0, 1);

    // Random traffic; a stalled request is held until accepted.
    hv = 1'b0; ha = '0; hw = '0; hs = '0; hst = '0;
    for (int i = 0; i < 500; i++) begin
      if (!hv || last_acc) begin
        hv  = ($urandom_range(0, 3) != 0);
        ha  = 32'($urandom_range(0, 63));
        hs  = 2'($urandom_range(0, 3));
        hst = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
        hw  = $urandom;
      end
      step(hv, ha, hs, hst, hw, ($urandom_range(0, 3) != 0));
    end
    repeat (2) step(0, 32'h0, 2, 4'h0, 32'h0, 1);
    chk("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
